// File: rtl/simon_seq_ctrl.sv
// Memory-game sequence controller: grows a random sequence one element per round,
// plays it back paced by TIMER_PULSE, checks the player's input and tracks scores.
module simon_seq_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_PULSES = 8,
  localparam int CH_W          = $clog2(NUM_CH),
  localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [CH_W-1:0]  RAND,
  input  logic             TIMER_PULSE,
  input  logic [CH_W-1:0]  IN,
  input  logic             IN_VALID,
  output logic [CH_W-1:0]  OUT,
  output logic             OUT_VALID,
  output logic [LEN_W-1:0] SCORE,
  output logic [LEN_W-1:0] HIGH_SCORE,
  output logic             ROUND_DONE,
  output logic             WIN,
  output logic             LOSE,
  output logic             HS_NEW
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int TMO_W = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_PULSES - 1);

  typedef enum logic [2:0] {
    IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN_S, LOSE_S, END_S
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  stack [MAX_LEN];
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] idx;
  logic [TMO_W-1:0] tmo;
  logic [CH_W-1:0]  rand_mod;
  logic [LEN_W-1:0] last_idx;
  logic [CH_W-1:0]  cur;

  // RAND is reduced in 32 bits so a power-of-two NUM_CH never wraps to a zero divisor.
  assign rand_mod = CH_W'(32'(RAND) % NUM_CH);
  assign last_idx = cnt - LEN_W'(1);
  assign cur      = stack[idx[IDX_W-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      tmo        <= '0;
      OUT        <= '0;
      OUT_VALID  <= 1'b0;
      SCORE      <= '0;
      HIGH_SCORE <= '0;
      ROUND_DONE <= 1'b0;
      WIN        <= 1'b0;
      LOSE       <= 1'b0;
      HS_NEW     <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) stack[k] <= '0;
    end else begin
      ROUND_DONE <= 1'b0;
      WIN        <= 1'b0;
      LOSE       <= 1'b0;
      HS_NEW     <= 1'b0;
      case (state)
        IDLE: begin
          OUT_VALID <= 1'b0;
          if (START) begin
            cnt   <= '0;
            SCORE <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          if (cnt == LEN_MAX) begin
            state <= WIN_S;
          end else begin
            stack[cnt[IDX_W-1:0]] <= rand_mod;
            cnt   <= cnt + LEN_W'(1);
            idx   <= '0;
            state <= SHOW_ON;
          end
        end
        SHOW_ON: begin
          OUT <= cur;
          if (TIMER_PULSE) begin
            OUT_VALID <= 1'b0;
            state     <= SHOW_OFF;
          end else begin
            OUT_VALID <= 1'b1;
          end
        end
        SHOW_OFF: begin
          // Dark gap keeps back-to-back repeats of one channel visible as two flashes.
          OUT_VALID <= 1'b0;
          if (TIMER_PULSE) begin
            if (idx == last_idx) begin
              idx   <= '0;
              tmo   <= '0;
              state <= INPUT;
            end else begin
              idx   <= idx + LEN_W'(1);
              state <= SHOW_ON;
            end
          end
        end
        INPUT: begin
          if (IN_VALID) begin
            tmo <= '0;
            if (IN == cur) begin
              if (idx == last_idx) begin
                SCORE      <= cnt;
                ROUND_DONE <= 1'b1;
                state      <= ADD;
              end else begin
                idx <= idx + LEN_W'(1);
              end
            end else begin
              state <= LOSE_S;
            end
          end else if (TIMER_PULSE) begin
            if (tmo == TMO_LAST) state <= LOSE_S;
            else tmo <= tmo + TMO_W'(1);
          end
        end
        WIN_S: begin
          WIN   <= 1'b1;
          SCORE <= LEN_MAX;
          state <= END_S;
        end
        LOSE_S: begin
          LOSE  <= 1'b1;
          state <= END_S;
        end
        END_S: begin
          if (SCORE > HIGH_SCORE) begin
            HIGH_SCORE <= SCORE;
            HS_NEW     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl with NUM_CH=3, MAX_LEN=4, TIMEOUT_PULSES=3:
// a cycle-by-cycle vector table for the first game, then hand-written game sequences.
module tb_simon_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] rnd;
  logic       tp;
  logic [1:0] in_code;
  logic       in_valid;
  logic [1:0] out_code;
  logic       out_valid;
  logic [2:0] score;
  logic [2:0] high_score;
  logic       round_done;
  logic       win;
  logic       lose;
  logic       hs_new;

  int checks = 0;
  int errors = 0;

  logic [1:0] seq [8];
  int len;

  simon_seq_ctrl #(.NUM_CH(3), .MAX_LEN(4), .TIMEOUT_PULSES(3)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .RAND(rnd), .TIMER_PULSE(tp),
    .IN(in_code), .IN_VALID(in_valid), .OUT(out_code), .OUT_VALID(out_valid),
    .SCORE(score), .HIGH_SCORE(high_score), .ROUND_DONE(round_done),
    .WIN(win), .LOSE(lose), .HS_NEW(hs_new)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [1:0] r;
    logic       p;
    logic [1:0] iv;
    logic       ivl;
    logic       e_ov;
    logic [1:0] e_out;
    logic       chk_out;
    logic [2:0] e_score;
    logic       e_rd;
    logic       e_lose;
    logic [2:0] e_hs;
    logic       e_hsn;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic [1:0] r, input logic p,
                      input logic [1:0] iv, input logic ivl);
    start = st; rnd = r; tp = p; in_code = iv; in_valid = ivl;
    @(posedge clk);
    #1;
  endtask

  task automatic new_game();
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    len = 0;
  endtask

  task automatic add(input int r);
    step(1'b0, 2'(r), 1'b0, 2'd0, 1'b0);
    seq[len] = 2'(r % 3);
    len++;
  endtask

  task automatic show();
    for (int k = 0; k < len; k++) begin
      step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      chk("show_on_valid", int'(out_valid), 1);
      chk("show_on_out", int'(out_code), int'(seq[k]));
      step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      chk("show_off_valid", int'(out_valid), 0);
      step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      chk("gap_valid", int'(out_valid), 0);
    end
  endtask

  task automatic answer_all();
    for (int k = 0; k < len; k++) begin
      step(1'b0, 2'd0, 1'b0, seq[k], 1'b1);
      chk("round_done", int'(round_done), (k == len - 1) ? 1 : 0);
    end
    chk("score_after_round", int'(score), len);
  endtask

  task automatic wrong(input int k);
    step(1'b0, 2'd0, 1'b0, 2'((int'(seq[k]) + 1) % 3), 1'b1);
    chk("lose_not_early", int'(lose), 0);
  endtask

  task automatic finish_loss(input int e_score, input int e_hs, input int e_hsn);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("lose_pulse", int'(lose), 1);
    chk("lose_score", int'(score), e_score);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("lose_pulse_len", int'(lose), 0);
    chk("end_high_score", int'(high_score), e_hs);
    chk("end_hs_new", int'(hs_new), e_hsn);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("idle_valid", int'(out_valid), 0);
    chk("hs_new_len", int'(hs_new), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st   r     p     iv    ivl  ov   out   co   sc    rd   lo   hs    hsn
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd2, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1, 1'b0};

    rst_n = 1'b0; start = 1'b0; rnd = 2'd0; tp = 1'b0; in_code = 2'd0; in_valid = 1'b0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out_code), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_high_score", int'(high_score), 0);
    chk("rst_pulses", int'({round_done, win, lose, hs_new}), 0);
    rst_n = 1'b1;

    // First game from the table: RAND=2 then RAND=3 (stored as 0), lose in round 2.
    for (int v = 0; v < 18; v++) begin
      step(vecs[v].st, vecs[v].r, vecs[v].p, vecs[v].iv, vecs[v].ivl);
      chk($sformatf("v%0d_out_valid", v), int'(out_valid), int'(vecs[v].e_ov));
      if (vecs[v].chk_out) chk($sformatf("v%0d_out", v), int'(out_code), int'(vecs[v].e_out));
      chk($sformatf("v%0d_score", v), int'(score), int'(vecs[v].e_score));
      chk($sformatf("v%0d_round_done", v), int'(round_done), int'(vecs[v].e_rd));
      chk($sformatf("v%0d_lose", v), int'(lose), int'(vecs[v].e_lose));
      chk($sformatf("v%0d_high_score", v), int'(high_score), int'(vecs[v].e_hs));
      chk($sformatf("v%0d_hs_new", v), int'(hs_new), int'(vecs[v].e_hsn));
    end

    // Three rounds correct, second input of round 4 wrong: new high score 3.
    new_game();
    chk("start_clears_score", int'(score), 0);
    add(1); show(); answer_all();
    add(2); show(); answer_all();
    add(3); show(); answer_all();
    add(0); show();
    step(1'b0, 2'd0, 1'b0, seq[0], 1'b1);
    chk("r4_first_ok", int'(round_done), 0);
    wrong(1);
    finish_loss(3, 3, 1);

    // Repeated channel 1,1 must flash twice; losing at 2 leaves high score alone.
    new_game();
    add(1); show(); answer_all();
    add(1); show(); answer_all();
    add(2); show();
    step(1'b0, 2'd0, 1'b0, seq[0], 1'b1);
    wrong(1);
    finish_loss(2, 3, 0);

    // All four rounds correct: win at MAX_LEN.
    new_game();
    add(2); show(); answer_all();
    add(0); show(); answer_all();
    add(1); show(); answer_all();
    add(2); show(); answer_all();
    step(1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
    chk("win_not_early", int'(win), 0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("win_pulse", int'(win), 1);
    chk("win_score", int'(score), 4);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("win_pulse_len", int'(win), 0);
    chk("win_high_score", int'(high_score), 4);
    chk("win_hs_new", int'(hs_new), 1);

    // Timeout: third pulse without input loses.
    new_game();
    add(1); show();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      chk("tmo_no_lose_yet", int'(lose), 0);
    end
    finish_loss(0, 4, 0);

    // Input coincident with the third pulse is taken and restarts the timeout.
    new_game();
    add(2); show(); answer_all();
    add(1); show();
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, seq[0], 1'b1);
    chk("tmo_coincident_lose", int'(lose), 0);
    chk("tmo_coincident_rd", int'(round_done), 0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0, seq[1], 1'b1);
    chk("tmo_restart_rd", int'(round_done), 1);
    chk("tmo_restart_score", int'(score), 2);

    // START during playback is ignored; reset mid-playback clears everything at once.
    add(0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("mid_show_valid", int'(out_valid), 1);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("start_ignored_valid", int'(out_valid), 1);
    chk("start_ignored_out", int'(out_code), int'(seq[0]));
    chk("start_ignored_score", int'(score), 2);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_high_score", int'(high_score), 0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_idle", int'(out_valid), 0);
    new_game();
    add(2);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_show", int'(out_valid), 1);
    chk("post_rst_out", int'(out_code), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
